// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct and opcode encodings, instruction field positions,
// and the decoded issue record handed from the decoder to the issue register.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CNT_W  = 16;

  localparam logic [5:0] FUNCT_NOP = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b001001;
  localparam logic [5:0] FUNCT_SUB = 6'b001010;
  localparam logic [5:0] FUNCT_AND = 6'b010001;
  localparam logic [5:0] FUNCT_SLL = 6'b100001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int OP_LSB    = 26;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic [5:0]            funct;
    logic [ALU_DATA_W-1:0] src1;
    logic [ALU_DATA_W-1:0] src2;
    logic [4:0]            shamt;
    logic [4:0]            rd;
    logic                  illegal;
  } issue_t;

  function automatic logic isAluFunct(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
           (funct == FUNCT_AND) || (funct == FUNCT_SLL);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in and writeback-out handshake channels of the ALU issue stage.
interface alu_issue_stage_if #(parameter int DATA_W = 32);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_carry;
  logic [4:0]        out_rd;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_rd, out_illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of an instruction word plus register values into ALU controls.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]           instr_i,
  input  logic [ALU_DATA_W-1:0] rsVal_i,
  input  logic [ALU_DATA_W-1:0] rtVal_i,
  output issue_t                issue_o
);

  logic [5:0]  opField;
  logic [5:0]  functField;
  logic [15:0] immField;
  logic [4:0]  unusedRsField;

  assign opField       = instr_i[OP_LSB +: 6];
  assign functField    = instr_i[FUNCT_LSB +: 6];
  assign immField      = instr_i[IMM_LSB +: 16];
  assign unusedRsField = instr_i[25:21];

  // Undecodable words default to a NOP that the ALU turns into result 0.
  always_comb begin
    issue_o         = '0;
    issue_o.funct   = FUNCT_NOP;
    issue_o.illegal = 1'b1;
    if (opField == OP_RTYPE && isAluFunct(functField)) begin
      issue_o.funct   = functField;
      issue_o.src1    = rsVal_i;
      issue_o.src2    = rtVal_i;
      issue_o.shamt   = instr_i[SHAMT_LSB +: 5];
      issue_o.rd      = instr_i[RD_LSB +: 5];
      issue_o.illegal = 1'b0;
    end else if (opField == OP_ADDI) begin
      issue_o.funct   = FUNCT_ADD;
      issue_o.src1    = rsVal_i;
      issue_o.src2    = {{(ALU_DATA_W-16){immField[15]}}, immField};
      issue_o.shamt   = 5'd0;
      issue_o.rd      = instr_i[RT_LSB +: 5];
      issue_o.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback pipeline around an external combinational ALU, with
// full valid/ready backpressure and retired/illegal counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = ALU_CNT_W
)(
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  issue_t            decoded;
  issue_t            iReg_q;
  logic              iValid_q;
  logic              wValid_q;
  logic [DATA_W-1:0] wResult_q;
  logic              wZero_q;
  logic              wCarry_q;
  logic [4:0]        wRd_q;
  logic              wIllegal_q;
  logic [CNT_W-1:0]  retiredCnt_q;
  logic [CNT_W-1:0]  illegalCnt_q;
  logic              inAccept;
  logic              iAdvance;
  logic              outFire;

  alu_issue_decode uDecode (
    .instr_i (bus.in_instr),
    .rsVal_i (bus.in_rs_val),
    .rtVal_i (bus.in_rt_val),
    .issue_o (decoded)
  );

  assign iAdvance     = iValid_q & (~wValid_q | bus.out_ready);
  assign bus.in_ready = ~iValid_q | iAdvance;
  assign inAccept     = bus.in_valid & bus.in_ready;
  assign outFire      = wValid_q & bus.out_ready;

  // The issue payload only changes on accept so the ALU inputs never glitch when I drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iValid_q <= 1'b0;
      iReg_q   <= '0;
    end else if (inAccept) begin
      iValid_q <= 1'b1;
      iReg_q   <= decoded;
    end else if (iAdvance) begin
      iValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wValid_q   <= 1'b0;
      wResult_q  <= '0;
      wZero_q    <= 1'b0;
      wCarry_q   <= 1'b0;
      wRd_q      <= 5'd0;
      wIllegal_q <= 1'b0;
    end else if (iAdvance) begin
      wValid_q   <= 1'b1;
      wResult_q  <= iReg_q.illegal ? '0 : alu_result;
      wZero_q    <= iReg_q.illegal ? 1'b1 : alu_zero;
      wCarry_q   <= iReg_q.illegal ? 1'b0 : alu_carry;
      wRd_q      <= iReg_q.rd;
      wIllegal_q <= iReg_q.illegal;
    end else if (outFire) begin
      wValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredCnt_q <= '0;
      illegalCnt_q <= '0;
    end else if (outFire) begin
      retiredCnt_q <= retiredCnt_q + CNT_W'(1);
      if (wIllegal_q) illegalCnt_q <= illegalCnt_q + CNT_W'(1);
    end
  end

  assign alu_src1        = iReg_q.src1;
  assign alu_src2        = iReg_q.src2;
  assign alu_shamt       = iReg_q.shamt;
  assign alu_funct       = iReg_q.funct;
  assign bus.out_valid   = wValid_q;
  assign bus.out_result  = wResult_q;
  assign bus.out_zero    = wZero_q;
  assign bus.out_carry   = wCarry_q;
  assign bus.out_rd      = wRd_q;
  assign bus.out_illegal = wIllegal_q;
  assign retired_cnt     = retiredCnt_q;
  assign illegal_cnt     = illegalCnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* ports, directed cases,
// a stalled stream, mid-operation reset and a randomized run against a queue model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic [15:0] retired_cnt;
  logic [15:0] illegal_cnt;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage_if #(.DATA_W(32)) bus ();

  alu_issue_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_shamt   (alu_shamt),
    .alu_funct   (alu_funct),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: carry is the adder carry-out for ADD and the borrow for SUB.
  always_comb begin
    alu_result = 32'd0;
    alu_carry  = 1'b0;
    case (alu_funct)
      6'b001001: {alu_carry, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
      6'b001010: begin
        alu_result = alu_src1 - alu_src2;
        alu_carry  = (alu_src1 < alu_src2);
      end
      6'b010001: alu_result = alu_src1 & alu_src2;
      6'b100001: alu_result = alu_src2 << alu_shamt;
      default:   alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  // What the instruction means architecturally, independent of how the stage decodes it.
  function automatic exp_t refModel(input logic [31:0] instr, input logic [31:0] rs,
                                    input logic [31:0] rt);
    exp_t        e;
    logic [63:0] wide;
    logic [31:0] immExt;
    logic [5:0]  op;
    logic [5:0]  fn;
    op      = instr[31:26];
    fn      = instr[5:0];
    immExt  = {{16{instr[15]}}, instr[15:0]};
    e.result  = 32'd0;
    e.carry   = 1'b0;
    e.rd      = instr[15:11];
    e.illegal = 1'b0;
    if (op == 6'h00 && fn == 6'h09) begin
      wide = {32'd0, rs} + {32'd0, rt};
      e.result = wide[31:0];
      e.carry  = wide[32];
    end else if (op == 6'h00 && fn == 6'h0A) begin
      e.result = rs - rt;
      e.carry  = (rt > rs);
    end else if (op == 6'h00 && fn == 6'h11) begin
      e.result = rs & rt;
    end else if (op == 6'h00 && fn == 6'h21) begin
      e.result = rt << instr[10:6];
    end else if (op == 6'h08) begin
      wide = {32'd0, rs} + {32'd0, immExt};
      e.result = wide[31:0];
      e.carry  = wide[32];
      e.rd     = instr[20:16];
    end else begin
      e.rd      = 5'd0;
      e.illegal = 1'b1;
    end
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w = {6'h00, w[25:6], 6'h09};
      1: w = {6'h00, w[25:6], 6'h0A};
      2: w = {6'h00, w[25:6], 6'h11};
      3: w = {6'h00, w[25:6], 6'h21};
      4: w = {6'h08, w[25:0]};
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard: handshakes are stable from the falling edge to the next rising edge.
  exp_t        expQ[$];
  logic [15:0] modelRetired = 16'd0;
  logic [15:0] modelIllegal = 16'd0;
  logic        prevStall    = 1'b0;
  logic        prevHoldI    = 1'b0;
  logic        sawBackpressure = 1'b0;
  logic [31:0] snapResult;
  logic [4:0]  snapRd;
  logic [31:0] snapSrc1;
  logic [31:0] snapSrc2;
  logic [5:0]  snapFunct;

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      modelRetired = 16'd0;
      modelIllegal = 16'd0;
      prevStall    = 1'b0;
      prevHoldI    = 1'b0;
    end else begin
      checkOutput("retired_cnt", {48'd0, retired_cnt}, {48'd0, modelRetired});
      checkOutput("illegal_cnt", {48'd0, illegal_cnt}, {48'd0, modelIllegal});
      if (prevStall) begin
        checkOutput("stall_result", {32'd0, bus.out_result}, {32'd0, snapResult});
        checkOutput("stall_rd", {59'd0, bus.out_rd}, {59'd0, snapRd});
      end
      if (prevHoldI) begin
        checkOutput("hold_src1", {32'd0, alu_src1}, {32'd0, snapSrc1});
        checkOutput("hold_src2", {32'd0, alu_src2}, {32'd0, snapSrc2});
        checkOutput("hold_funct", {58'd0, alu_funct}, {58'd0, snapFunct});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("sb_result", {32'd0, bus.out_result}, {32'd0, e.result});
          checkOutput("sb_flags", {61'd0, bus.out_zero, bus.out_carry, bus.out_illegal},
                      {61'd0, e.zero, e.carry, e.illegal});
          checkOutput("sb_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
          modelRetired = modelRetired + 16'd1;
          if (e.illegal) modelIllegal = modelIllegal + 16'd1;
        end
      end
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(refModel(bus.in_instr, bus.in_rs_val, bus.in_rt_val));
      if (bus.in_valid && !bus.in_ready) sawBackpressure = 1'b1;
      prevStall  = bus.out_valid && !bus.out_ready;
      prevHoldI  = !bus.in_ready;
      snapResult = bus.out_result;
      snapRd     = bus.out_rd;
      snapSrc1   = alu_src1;
      snapSrc2   = alu_src2;
      snapFunct  = alu_funct;
    end
  end

  // Holds one op on the input until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs,
                               input logic [31:0] rt);
    bit accepted;
    accepted         = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_instr     = instr;
    bus.in_rs_val    = rs;
    bus.in_rt_val    = rt;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [31:0] instr,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] expResult, input logic [2:0] expFlags,
                             input logic [4:0] expRd);
    applyStimulus(instr, rs, rt);
    checkOutput({tag, "_early"}, {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    checkOutput({tag, "_result"}, {32'd0, bus.out_result}, {32'd0, expResult});
    checkOutput({tag, "_flags"}, {61'd0, bus.out_zero, bus.out_carry, bus.out_illegal},
                {61'd0, expFlags});
    checkOutput({tag, "_rd"}, {59'd0, bus.out_rd}, {59'd0, expRd});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          randDone;
    logic [15:0] startRetired;
    logic [15:0] startIllegal;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_rs_val = 32'd0;
    bus.in_rt_val = 32'd0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_funct", {58'd0, alu_funct}, 64'd0);
    checkOutput("reset_result", {32'd0, bus.out_result}, 64'd0);
    checkOutput("reset_cnt", {32'd0, retired_cnt, illegal_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // flags ordering is {zero, carry, illegal}
    runDirected("add", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h09}, 32'd5, 32'd7, 32'd12, 3'b000, 5'd3);
    runDirected("sub_zero", {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h0A}, 32'h1234, 32'h1234,
                32'd0, 3'b100, 5'd4);
    runDirected("sub_borrow", {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h0A}, 32'd1, 32'd2,
                32'hFFFF_FFFF, 3'b010, 5'd5);
    runDirected("addi", {6'h08, 5'd1, 5'd9, 16'hFFFF}, 32'd10, 32'd77, 32'd9, 3'b010, 5'd9);
    runDirected("sll", {6'h00, 5'd0, 5'd1, 5'd6, 5'd31, 6'h21}, 32'd99, 32'd1,
                32'h8000_0000, 3'b000, 5'd6);
    startRetired = retired_cnt;
    startIllegal = illegal_cnt;
    runDirected("illegal", {6'h3F, 26'h0123456}, 32'hDEAD, 32'hBEEF, 32'd0, 3'b101, 5'd0);
    checkOutput("illegal_cnt_step", {48'd0, illegal_cnt}, {48'd0, startIllegal + 16'd1});
    checkOutput("retired_cnt_step", {48'd0, retired_cnt}, {48'd0, startRetired + 16'd1});

    // Back-to-back stream with a three-cycle consumer stall in the middle.
    startRetired    = retired_cnt;
    sawBackpressure = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(randInstr(), $urandom, $urandom);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stream_retired", {48'd0, retired_cnt}, {48'd0, startRetired + 16'd8});
    checkOutput("stream_backpressure", {63'd0, sawBackpressure}, 64'd1);
    checkOutput("stream_drained", 64'(expQ.size()), 64'd0);

    // Fill both stages, then reset mid-cycle.
    bus.out_ready = 1'b0;
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h09}, 32'd1, 32'd1);
    applyStimulus({6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h11}, 32'hF0, 32'h3C);
    checkOutput("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("async_funct", {58'd0, alu_funct}, 64'd0);
    checkOutput("async_cnt", {48'd0, retired_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    runDirected("resume", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h11}, 32'hFF00, 32'h0FF0,
                32'h0F00, 3'b000, 5'd3);
    checkOutput("resume_cnt", {48'd0, retired_cnt}, 64'd1);

    // Randomized traffic with random consumer readiness.
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(randInstr(), $urandom, $urandom);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("random_drained", 64'(expQ.size()), 64'd0);
    checkOutput("random_out_idle", {63'd0, bus.out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
